ddr_rd_resp_checker: RTL

- Downstream consumer of the DDR test master's transactions. Accepts the write-response (B) and read-data (R) channels returned by the DDR controller.
- Compares every read beat against an expected incrementing pattern and reports pass/fail, error counts and timeouts.
- Drives the board status indication for the DDR write/read self-test.

---
 rtl/ddr_test_pkg.sv | 27 ++
 rtl/ddr_timeout_ctr.sv | 36 +++
 rtl/ddr_rd_resp_checker.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR write/read self-test: response codes,
// checker FSM encoding, default data width and the common test pattern.
package ddr_test_pkg;

  localparam int           DDR_DATA_W       = 128;
  localparam logic [127:0] DDR_TEST_PATTERN = 128'h00000000_00000000_12345678_87654321;
  localparam logic [1:0]   RESP_OKAY        = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_B = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_FINISH = 2'd3
  } chk_state_e;

  // Saturating add of a small increment to an 8-bit error/beat counter.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0000000, inc};
    if (sum[8]) begin
      sat_add8 = 8'hFF;
    end else begin
      sat_add8 = sum[7:0];
    end
  endfunction

endpackage

// File: rtl/ddr_timeout_ctr.sv
// Wait-cycle counter for the response checker: clears on demand, counts
// enabled cycles and flags expiry once the count reaches TIMEOUT_CYC-1.
module ddr_timeout_ctr
  import ddr_test_pkg::*;
#(
  parameter int              TO_W        = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = 24'd1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] LIMIT = TIMEOUT_CYC - ONE;

  logic [TO_W-1:0] cnt_r;

  // Counter holds at the limit so expiry stays visible until cleared.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_r <= {TO_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {TO_W{1'b0}};
    end else if (en && !expired) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == LIMIT);

endmodule

// File: rtl/ddr_rd_resp_checker.sv
// Consumes B and R responses of the DDR self-test, checks read beats against
// an incrementing pattern and reports pass/fail, error/beat counts, timeout.
module ddr_rd_resp_checker
  import ddr_test_pkg::*;
#(
  parameter int              DATA_W      = DDR_DATA_W,
  parameter int              TO_W        = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = 24'd1000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [7:0]        exp_len,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic [7:0]        beat_cnt,
  output logic              timeout
);

  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  chk_state_e        state_r, state_nxt_s;
  logic [DATA_W-1:0] exp_cur_r, exp_cur_nxt_s;
  logic [7:0]        exp_len_r, exp_len_nxt_s;
  logic [8:0]        beat_idx_r, beat_idx_nxt_s;
  logic              bready_r, bready_nxt_s;
  logic              rready_r, rready_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              pass_r, pass_nxt_s;
  logic              timeout_r, timeout_nxt_s;
  logic [7:0]        err_cnt_r, err_cnt_nxt_s;
  logic [7:0]        beat_cnt_r, beat_cnt_nxt_s;

  logic              b_hs_s, r_hs_s;
  logic              beat_bad_s, idx_last_s, len_err_s;
  logic [1:0]        beat_err_inc_s;
  logic              tmr_clr_s, tmr_en_s, tmr_exp_s;

  assign b_hs_s     = (state_r == ST_WAIT_B) && bvalid && bready_r;
  assign r_hs_s     = (state_r == ST_WAIT_R) && rvalid && rready_r;
  // Data mismatch and bad response on one beat count as a single error.
  assign beat_bad_s = (rdata != exp_cur_r) || (rresp != RESP_OKAY);
  assign idx_last_s = (beat_idx_r == {1'b0, exp_len_r});
  // Length error: rlast on the wrong beat, or no rlast on the expected last beat.
  assign len_err_s  = rlast ^ idx_last_s;
  assign beat_err_inc_s = {1'b0, beat_bad_s} + {1'b0, len_err_s};

  ddr_timeout_ctr #(
    .TO_W        (TO_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (tmr_clr_s),
    .en      (tmr_en_s),
    .expired (tmr_exp_s)
  );

  // State and result registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      exp_cur_r  <= {DATA_W{1'b0}};
      exp_len_r  <= 8'd0;
      beat_idx_r <= 9'd0;
      bready_r   <= 1'b0;
      rready_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      timeout_r  <= 1'b0;
      err_cnt_r  <= 8'd0;
      beat_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      exp_cur_r  <= exp_cur_nxt_s;
      exp_len_r  <= exp_len_nxt_s;
      beat_idx_r <= beat_idx_nxt_s;
      bready_r   <= bready_nxt_s;
      rready_r   <= rready_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      pass_r     <= pass_nxt_s;
      timeout_r  <= timeout_nxt_s;
      err_cnt_r  <= err_cnt_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_WAIT_B;
        else       state_nxt_s = ST_IDLE;
      end
      ST_WAIT_B: begin
        if (b_hs_s)         state_nxt_s = ST_WAIT_R;
        else if (tmr_exp_s) state_nxt_s = ST_FINISH;
        else                state_nxt_s = ST_WAIT_B;
      end
      ST_WAIT_R: begin
        if (r_hs_s)         state_nxt_s = rlast ? ST_FINISH : ST_WAIT_R;
        else if (tmr_exp_s) state_nxt_s = ST_FINISH;
        else                state_nxt_s = ST_WAIT_R;
      end
      ST_FINISH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pattern tracker and timer control.
  always_comb begin
    exp_cur_nxt_s  = exp_cur_r;
    exp_len_nxt_s  = exp_len_r;
    beat_idx_nxt_s = beat_idx_r;
    bready_nxt_s   = 1'b0;
    rready_nxt_s   = 1'b0;
    busy_nxt_s     = busy_r;
    done_nxt_s     = done_r;
    pass_nxt_s     = pass_r;
    timeout_nxt_s  = timeout_r;
    err_cnt_nxt_s  = err_cnt_r;
    beat_cnt_nxt_s = beat_cnt_r;
    tmr_clr_s      = 1'b0;
    tmr_en_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          exp_cur_nxt_s  = exp_data;
          exp_len_nxt_s  = exp_len;
          beat_idx_nxt_s = 9'd0;
          err_cnt_nxt_s  = 8'd0;
          beat_cnt_nxt_s = 8'd0;
          done_nxt_s     = 1'b0;
          pass_nxt_s     = 1'b0;
          timeout_nxt_s  = 1'b0;
          busy_nxt_s     = 1'b1;
          bready_nxt_s   = 1'b1;
          tmr_clr_s      = 1'b1;
        end else begin
          busy_nxt_s = busy_r;
        end
      end
      ST_WAIT_B: begin
        if (b_hs_s) begin
          err_cnt_nxt_s = sat_add8(err_cnt_r, {1'b0, (bresp != RESP_OKAY)});
          rready_nxt_s  = 1'b1;
          tmr_clr_s     = 1'b1;
        end else if (tmr_exp_s) begin
          timeout_nxt_s = 1'b1;
          err_cnt_nxt_s = sat_add8(err_cnt_r, 2'd1);
        end else begin
          bready_nxt_s = 1'b1;
          tmr_en_s     = 1'b1;
        end
      end
      ST_WAIT_R: begin
        if (r_hs_s) begin
          err_cnt_nxt_s  = sat_add8(err_cnt_r, beat_err_inc_s);
          beat_cnt_nxt_s = sat_add8(beat_cnt_r, 2'd1);
          beat_idx_nxt_s = (beat_idx_r == 9'h1FF) ? beat_idx_r : beat_idx_r + 9'd1;
          exp_cur_nxt_s  = exp_cur_r + DATA_ONE;
          rready_nxt_s   = !rlast;
          tmr_clr_s      = 1'b1;
        end else if (tmr_exp_s) begin
          timeout_nxt_s = 1'b1;
          err_cnt_nxt_s = sat_add8(err_cnt_r, 2'd1);
        end else begin
          rready_nxt_s = 1'b1;
          tmr_en_s     = 1'b1;
        end
      end
      ST_FINISH: begin
        done_nxt_s = 1'b1;
        busy_nxt_s = 1'b0;
        pass_nxt_s = (err_cnt_r == 8'd0) && !timeout_r;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  assign bready   = bready_r;
  assign rready   = rready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign pass     = pass_r;
  assign err_cnt  = err_cnt_r;
  assign beat_cnt = beat_cnt_r;
  assign timeout  = timeout_r;

endmodule
